// File: rtl/seq_edge_pkg.sv
// Shared definitions for the edge-counter family.
//   edge_mode_e  : run-time edge selection (any / rising / falling / none)
//   edge_sel_bit : per-bit edge detect for the selected mode
package seq_edge_pkg;

  typedef enum logic [1:0] {
    EDGE_ANY  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_NONE = 2'b11
  } edge_mode_e;

  // Applied bit by bit so that callers of any width can use it without
  // a width-parameterised function.
  function automatic logic edge_sel_bit(edge_mode_e m, logic cur, logic prv);
    logic r;
    r = 1'b0;
    case (m)
      EDGE_ANY:  r = cur ^ prv;
      EDGE_RISE: r = cur & ~prv;
      EDGE_FALL: r = ~cur & prv;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_edge_count_multi_popcount.sv
// Combinational population count.
//   in_i    [WIDTH-1:0]           : vector to count
//   count_o [$clog2(WIDTH+1)-1:0] : number of set bits in in_i
module popcount #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]             in_i,
  output logic [$clog2(WIDTH+1)-1:0]   count_o
);

  localparam int unsigned OUT_W = $clog2(WIDTH + 1);

  logic [OUT_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      acc = acc + OUT_W'(in_i[i]);
    end
  end

  assign count_o = acc;

endmodule

// File: rtl/seq_edge_count_multi.sv
// Multi-bit edge counter with run-time edge selection.
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset
//   clear  : synchronous clear, same effect as reset
//   en     : counting enable
//   mode   : 00 any, 01 rising, 10 falling, 11 none
//   in_    : monitored vector
//   thresh : threshold for hit
//   count  : registered accumulated edge count (wraps or saturates)
//   hit    : registered sticky flag, set once count reaches thresh
module seq_edge_count_multi
  import seq_edge_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CNT_W    = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in_,
  input  logic [CNT_W-1:0] thresh,
  output logic [CNT_W-1:0] count,
  output logic             hit
);

  localparam int unsigned PC_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             hit_q, hit_d;

  logic [WIDTH-1:0] sel;
  logic [PC_W-1:0]  n;
  logic [CNT_W:0]   sum;
  edge_mode_e       mode_e;

  assign mode_e = edge_mode_e'(mode);

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sel[i] = edge_sel_bit(mode_e, in_[i], prev_q[i]);
    end
  end

  popcount #(.WIDTH(WIDTH)) u_popcount (
    .in_i    (sel),
    .count_o (n)
  );

  // One extra bit so the saturating clamp can see the carry out.
  assign sum = {1'b0, count_q} + (CNT_W + 1)'(n);

  always_comb begin
    prev_d  = in_;
    count_d = count_q;
    if (en) begin
      if (SATURATE) begin
        count_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      end else begin
        count_d = sum[CNT_W-1:0];
      end
    end
    hit_d = hit_q | (count_d >= thresh);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      prev_q  <= '0;
      count_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      count_q <= count_d;
      hit_q   <= hit_d;
    end
  end

  assign count = count_q;
  assign hit   = hit_q;

endmodule

// File: tb/tb_seq_edge_count_multi.sv
module tb_seq_edge_count_multi;

  logic       clk = 1'b0;
  logic       reset, clear, en;
  logic [1:0] mode;
  logic [7:0] in_;
  logic [7:0] thresh;
  logic [3:0] thresh4;

  logic [7:0] cnt_a;
  logic [3:0] cnt_b, cnt_c;
  logic       hit_a, hit_b, hit_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign thresh4 = thresh[3:0];

  // A: default 8/8 wrap, B: 4-bit saturating, C: 4-bit wrapping
  seq_edge_count_multi #(.WIDTH(8), .CNT_W(8), .SATURATE(1'b0)) u_a (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .mode(mode),
    .in_(in_), .thresh(thresh), .count(cnt_a), .hit(hit_a));
  seq_edge_count_multi #(.WIDTH(8), .CNT_W(4), .SATURATE(1'b1)) u_b (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .mode(mode),
    .in_(in_), .thresh(thresh4), .count(cnt_b), .hit(hit_b));
  seq_edge_count_multi #(.WIDTH(8), .CNT_W(4), .SATURATE(1'b0)) u_c (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .mode(mode),
    .in_(in_), .thresh(thresh4), .count(cnt_c), .hit(hit_c));

  // ---------------- behavioural model ----------------
  int         m_cnt [3];
  bit         m_hit [3];
  logic [7:0] m_prev;
  bit         model_valid = 1'b0;
  int         cmax  [3] = '{255, 15, 15};
  bit         csat  [3] = '{1'b0, 1'b1, 1'b0};

  function automatic int edges(input logic [1:0] md, input logic [7:0] cur, input logic [7:0] prv);
    int k;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (md == 2'd0 && cur[i] != prv[i]) k++;
      if (md == 2'd1 && cur[i] && !prv[i]) k++;
      if (md == 2'd2 && !cur[i] && prv[i]) k++;
    end
    return k;
  endfunction

  always @(posedge clk) begin
    int n, s, th;
    if (reset || clear) begin
      for (int j = 0; j < 3; j++) begin
        m_cnt[j] = 0;
        m_hit[j] = 1'b0;
      end
      m_prev = 8'h00;
      model_valid = 1'b1;
    end else if (model_valid) begin
      n = edges(mode, in_, m_prev);
      for (int j = 0; j < 3; j++) begin
        th = (j == 0) ? int'(thresh) : int'(thresh4);
        if (en) begin
          s = m_cnt[j] + n;
          if (csat[j]) m_cnt[j] = (s > cmax[j]) ? cmax[j] : s;
          else         m_cnt[j] = s % (cmax[j] + 1);
        end
        if (m_cnt[j] >= th) m_hit[j] = 1'b1;
      end
      m_prev = in_;
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (model_valid) begin
      checks += 6;
      if (int'(cnt_a) != m_cnt[0]) begin errors++; $display("FAIL model_cnt_a got %0d want %0d", cnt_a, m_cnt[0]); end
      if (int'(cnt_b) != m_cnt[1]) begin errors++; $display("FAIL model_cnt_b got %0d want %0d", cnt_b, m_cnt[1]); end
      if (int'(cnt_c) != m_cnt[2]) begin errors++; $display("FAIL model_cnt_c got %0d want %0d", cnt_c, m_cnt[2]); end
      if (hit_a != m_hit[0]) begin errors++; $display("FAIL model_hit_a got %0b want %0b", hit_a, m_hit[0]); end
      if (hit_b != m_hit[1]) begin errors++; $display("FAIL model_hit_b got %0b want %0b", hit_b, m_hit[1]); end
      if (hit_c != m_hit[2]) begin errors++; $display("FAIL model_hit_c got %0b want %0b", hit_c, m_hit[2]); end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input logic [7:0] v, input logic e, input logic [1:0] md,
                     input logic clr, input logic rst);
    in_ = v; en = e; mode = md; clear = clr; reset = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; en = 1'b0; mode = 2'd0; in_ = 8'h00; thresh = 8'hFF;

    // reset state
    cyc(8'h00, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("reset_cnt", cnt_a, 0);
    chk("reset_hit", hit_a, 0);

    // any mode
    cyc(8'hFF, 1'b1, 2'd0, 1'b0, 1'b0); chk("any_1", cnt_a, 8);
    cyc(8'h00, 1'b1, 2'd0, 1'b0, 1'b0); chk("any_2", cnt_a, 16);
    cyc(8'h0F, 1'b1, 2'd0, 1'b0, 1'b0); chk("any_3", cnt_a, 20);

    // saturate vs wrap at 4 bits
    cyc(8'h00, 1'b0, 2'd0, 1'b0, 1'b1);
    cyc(8'h00, 1'b1, 2'd0, 1'b0, 1'b0); chk("sat_0", cnt_b, 0);
    cyc(8'hFF, 1'b1, 2'd0, 1'b0, 1'b0); chk("sat_8", cnt_b, 8);  chk("wrap_8", cnt_c, 8);
    cyc(8'h00, 1'b1, 2'd0, 1'b0, 1'b0); chk("sat_15", cnt_b, 15); chk("wrap_0", cnt_c, 0);
    cyc(8'hFF, 1'b1, 2'd0, 1'b0, 1'b0); chk("sat_hold", cnt_b, 15);

    // rising
    cyc(8'h00, 1'b1, 2'd1, 1'b1, 1'b0);
    cyc(8'h00, 1'b1, 2'd1, 1'b0, 1'b0); chk("rise_0", cnt_a, 0);
    cyc(8'hAA, 1'b1, 2'd1, 1'b0, 1'b0); chk("rise_4", cnt_a, 4);
    cyc(8'h55, 1'b1, 2'd1, 1'b0, 1'b0); chk("rise_8", cnt_a, 8);
    // falling
    cyc(8'h00, 1'b1, 2'd2, 1'b1, 1'b0); chk("clear_cnt", cnt_a, 0);
    cyc(8'h00, 1'b1, 2'd2, 1'b0, 1'b0); chk("fall_0a", cnt_a, 0);
    cyc(8'hAA, 1'b1, 2'd2, 1'b0, 1'b0); chk("fall_0b", cnt_a, 0);
    cyc(8'h55, 1'b1, 2'd2, 1'b0, 1'b0); chk("fall_4", cnt_a, 4);

    // enable off, prev tracking, mode none
    cyc(8'h00, 1'b0, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc((i % 2) ? 8'hFF : 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("en_off", cnt_a, 0);
    cyc(8'hFF, 1'b1, 2'd0, 1'b0, 1'b0); chk("en_tracked", cnt_a, 0);
    for (int i = 0; i < 4; i++) cyc((i % 2) ? 8'hFF : 8'h00, 1'b1, 2'd3, 1'b0, 1'b0);
    chk("mode_none", cnt_a, 0);

    // threshold
    thresh = 8'd12;
    cyc(8'h00, 1'b1, 2'd0, 1'b1, 1'b0);
    cyc(8'hFF, 1'b1, 2'd0, 1'b0, 1'b0); chk("th_cnt8", cnt_a, 8);  chk("th_hit0", hit_a, 0);
    cyc(8'hF0, 1'b1, 2'd0, 1'b0, 1'b0); chk("th_cnt12", cnt_a, 12); chk("th_hit1", hit_a, 1);
    cyc(8'hF1, 1'b1, 2'd0, 1'b0, 1'b0); chk("th_cnt13", cnt_a, 13); chk("th_sticky", hit_a, 1);
    cyc(8'hF1, 1'b1, 2'd0, 1'b1, 1'b0); chk("th_clr_cnt", cnt_a, 0); chk("th_clr_hit", hit_a, 0);
    thresh = 8'hFF;

    // mid-run clear with edges present
    cyc(8'h00, 1'b1, 2'd0, 1'b0, 1'b1);
    cyc(8'hFF, 1'b1, 2'd0, 1'b0, 1'b0); chk("mid_8", cnt_a, 8);
    cyc(8'hFF, 1'b1, 2'd0, 1'b1, 1'b0); chk("mid_clr", cnt_a, 0);
    cyc(8'hFF, 1'b1, 2'd0, 1'b0, 1'b0); chk("mid_again", cnt_a, 8);

    // clear overrides enable; thresh 0 hits on first free cycle
    thresh = 8'd0;
    cyc(8'h00, 1'b1, 2'd0, 1'b1, 1'b0); chk("th0_clr", hit_a, 0);
    cyc(8'h00, 1'b0, 2'd0, 1'b0, 1'b0); chk("th0_hit", hit_a, 1);

    // wrap past thresh keeps hit (4-bit wrap instance, thresh 6)
    thresh = 8'd6;
    cyc(8'h00, 1'b1, 2'd0, 1'b1, 1'b0);
    cyc(8'hFF, 1'b1, 2'd0, 1'b0, 1'b0); chk("wth_hit", hit_c, 1);
    cyc(8'h00, 1'b1, 2'd0, 1'b0, 1'b0); chk("wth_cnt", cnt_c, 0); chk("wth_keep", hit_c, 1);

    // mode/thresh changes mid-stream and a few mixed patterns for the model
    thresh = 8'd40;
    cyc(8'h3C, 1'b1, 2'd1, 1'b0, 1'b0);
    cyc(8'hC3, 1'b1, 2'd2, 1'b0, 1'b0);
    cyc(8'h5A, 1'b1, 2'd0, 1'b0, 1'b0);
    cyc(8'h01, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(8'hFE, 1'b1, 2'd0, 1'b0, 1'b0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_edge_count_multi.md
# seq_edge_count_multi

Parametrised multi-bit edge counter. Compares each bit of an input vector against its value on the previous cycle and selects edges by run-time mode: any, rising, falling or disabled. It accumulates the number of selected edges per cycle into a counter that either wraps or saturates, and raises a sticky flag when the count reaches a programmable threshold. It replaces the fixed 8-bit any-edge counter in the sequential-block library.

## Interface
- `WIDTH`, default 8: number of monitored input bits; must be at least 1.
- `CNT_W`, default 8: counter width; must be at least `$clog2(WIDTH+1)`.
- `SATURATE`, default 0: 0 makes the counter wrap modulo 2^CNT_W; 1 makes it saturate at 2^CNT_W-1.
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `clear`, input, 1: synchronous clear; same effect as `reset` on all state.
- `en`, input, 1: counting enable.
- `mode`, input, 2: edge select. 00 any, 01 rising, 10 falling, 11 none.
- `in_`, input, WIDTH: monitored vector.
- `thresh`, input, CNT_W: threshold for `hit`.
- `count`, output, CNT_W: registered accumulated edge count.
- `hit`, output, 1: registered sticky flag; set once `count` reaches `thresh`.

## Operation
- Registers:
  - `prev`, WIDTH bits.
  - `count`, CNT_W bits.
  - `hit`, 1 bit.
- When `reset` or `clear` is high, all three registers are 0. `clear` overrides every other input.
- Per-bit edge masks:
  - rise = `in_` & ~`prev`
  - fall = ~`in_` & `prev`
  - any = `in_` ^ `prev`
- The mask selected by `mode` gives `sel`. Mode 11 gives `sel` = 0.
- `n` = popcount(`sel`), range 0..WIDTH.
- Next count:
  - If `en` = 0, `count` holds.
  - If `en` = 1 and SATURATE = 0, `count` + `n` mod 2^CNT_W.
  - If `en` = 1 and SATURATE = 1, min(`count` + `n`, 2^CNT_W-1). The sum is computed at CNT_W+1 bits before clamping.
- `prev` loads `in_` every non-reset, non-clear cycle, whatever `en` and `mode` are. Edges that occur while disabled are therefore lost; they are not deferred.
- `hit` is set on the cycle whose next `count` is >= `thresh`, using next-count and `thresh` sampled that cycle. It stays set until `reset` or `clear`.
- With `thresh` = 0, `hit` becomes 1 on the first non-reset, non-clear cycle.
- After the first cycle out of reset, `prev` = 0. A high bit on `in_` in that cycle therefore counts as a rising edge.
- `mode` and `thresh` may change on any cycle and take effect in the same cycle.
- In wrap mode, a wrap past `thresh` does not clear `hit`.

## Timing
- Edge latency: an edge on `in_` sampled at rising edge t is visible on `count` after edge t (1 cycle).
- `hit` updates on the same edge as the `count` that crosses the threshold; the two are never skewed.
- `reset` or `clear` asserted at edge t gives `count` = 0, `hit` = 0 and `prev` = 0 after edge t. Edges present at edge t are discarded.
- No handshake: `in_` is sampled every cycle.

## Structure
- Shared package `seq_edge_pkg` holds:
  - typedef `edge_mode_e` (EDGE_ANY, EDGE_RISE, EDGE_FALL, EDGE_NONE) on 2 bits;
  - the mask-select function.
- Sub-module `popcount #(WIDTH)`: combinational, output `$clog2(WIDTH+1)` bits, loop-based adder chain. It is reused by later blocks.
- Top level holds the three registers, mode mux, saturating/wrapping adder and threshold compare.

## Test plan
All scenarios use WIDTH=8, CNT_W=8, SATURATE=0 unless stated. "Reset" means reset is asserted, then released.
- Any mode: reset, then `in_` = 0xFF, 0x00, 0x0F, each for one cycle, `en` = 1, `mode` = 00. Required: `count` = 8, then 16, then 20.
- Rising vs falling: `in_` sequence 0x00 → 0xAA → 0x55. In mode 01, `count` = 0, 4, 8. Repeat in mode 10 after clear: `count` = 0, 0, 4.
- Saturate/wrap: CNT_W=4, mode 00, `in_` toggles 0x00/0xFF each cycle for 3 cycles. With SATURATE=1, `count` = 0, 8, 15 and then stays at 15. With SATURATE=0, `count` = 0, 8, 0.
- Enable and mode none:
  - `en` = 0 while `in_` toggles 0x00/0xFF for 4 cycles: `count` stays 0.
  - Then `en` = 1 with `in_` held at 0xFF: `count` stays 0, because `prev` tracked.
  - `mode` = 11 with toggling: `count` holds.
- Threshold: `thresh` = 12, mode 00, `in_` 0xFF → 0xF0 → 0xF1. Required: `hit` = 0 with `count` = 8; then `hit` = 1 with `count` = 12; `hit` stays 1 at `count` = 13. Clear gives `hit` = 0 and `count` = 0 next cycle.
- Mid-run clear: `in_` = 0xFF and `clear` = 1 on the same cycle after `count` = 8. Required: `count` = 0. The next cycle with `in_` = 0xFF counts 8, since `prev` = 0.
